// File: rtl/proc_test_pkg.sv
// rtl/proc_test_pkg.sv - shared state encoding and fill-pattern default for the test sequencer
package proc_test_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_HOLD,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [31:0] INIT_PATTERN_DEFAULT = 32'hcafebabe;

endpackage

// File: rtl/tb_cycle_counter.sv
// rtl/tb_cycle_counter.sv - loadable 16-bit down-counter with zero flag
module tb_cycle_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        en,
   output logic        zero
);

   logic [15:0] count;

   // Stops at zero rather than wrapping, so an idle enable is harmless.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != '0)) begin
         count <= count - 16'd1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/proc_test_sequencer.sv
// rtl/proc_test_sequencer.sv - init / reset-hold / run / register-check sequencer for a processor under test
module proc_test_sequencer
   import proc_test_pkg::*;
#(
   parameter int          DATA_W       = 32,
   parameter int          NREG         = 32,
   parameter int          RESET_CYCLES = 2,
   parameter logic [31:0] INIT_PATTERN = INIT_PATTERN_DEFAULT,
   localparam int         ADDR_W       = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       run_cycles,
   input  logic              stop_on_fail,
   output logic              proc_reset,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   input  logic [DATA_W-1:0] exp_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_idx,
   output logic [DATA_W-1:0] fail_act,
   output logic [DATA_W-1:0] fail_exp,
   output logic [ADDR_W:0]   mismatch_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);
   localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(NREG - 1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       run_q;
   logic              stop_q;
   logic              start_ok, mismatch, last_addr, done_stay;
   logic              cnt_load, cnt_en, cnt_zero;
   logic [15:0]       cnt_value;

   assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
   assign mismatch  = (state == S_CHECK) && (reg_rdata != exp_data);
   assign last_addr = (addr == LAST_ADDR);
   assign done_stay = (state == S_DONE) && (state_next == S_DONE);
   assign reg_addr  = addr;
   assign reg_wdata = DATA_W'(INIT_PATTERN);

   // Counter is preloaded with length-1 so the zero flag marks the last cycle of HOLD/RUN.
   assign cnt_load  = ((state == S_INIT) && last_addr) || ((state == S_HOLD) && cnt_zero);
   assign cnt_value = (state == S_INIT) ? 16'(RESET_CYCLES - 1) : (run_q - 16'd1);
   assign cnt_en    = (state == S_HOLD) || (state == S_RUN);

   tb_cycle_counter u_cycle_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (cnt_value),
      .en         (cnt_en),
      .zero       (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_next = S_INIT;
         S_INIT:         if (last_addr) state_next = S_HOLD;
         S_HOLD:         if (cnt_zero) state_next = (run_q == '0) ? S_CHECK : S_RUN;
         S_RUN:          if (cnt_zero) state_next = S_CHECK;
         S_CHECK:        if ((mismatch && stop_q) || last_addr) state_next = S_DONE;
         default:        state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      proc_reset = 1'b1;
      reg_we     = 1'b0;
      case (state)
         S_INIT: begin
            busy   = 1'b1;
            reg_we = 1'b1;
         end
         S_HOLD, S_CHECK: busy = 1'b1;
         S_RUN: begin
            busy       = 1'b1;
            proc_reset = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr           <= '0;
         run_q          <= '0;
         stop_q         <= 1'b0;
         fail_idx       <= '0;
         fail_act       <= '0;
         fail_exp       <= '0;
         mismatch_count <= '0;
         done           <= 1'b0;
         pass           <= 1'b0;
      end else begin
         done <= done_stay;
         pass <= done_stay && (mismatch_count == '0);
         if (start_ok) begin
            run_q          <= run_cycles;
            stop_q         <= stop_on_fail;
            fail_idx       <= '0;
            fail_act       <= '0;
            fail_exp       <= '0;
            mismatch_count <= '0;
            addr           <= ADDR_W'(1);
         end else if (state == S_INIT) begin
            addr <= last_addr ? '0 : addr + ADDR_W'(1);
         end else if (state_next == S_CHECK && state != S_CHECK) begin
            addr <= ADDR_W'(1);
         end else if (state == S_CHECK) begin
            addr <= (state_next == S_DONE) ? '0 : addr + ADDR_W'(1);
            if (mismatch) begin
               if (mismatch_count != MAX_COUNT) mismatch_count <= mismatch_count + (ADDR_W + 1)'(1);
               if (mismatch_count == '0) begin
                  fail_idx <= addr;
                  fail_act <= reg_rdata;
                  fail_exp <= exp_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_proc_test_sequencer.sv
// tb/tb_proc_test_sequencer.sv - scoreboard bench for proc_test_sequencer
module tb_proc_test_sequencer;

   localparam int NREG   = 32;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stop_on_fail = 1'b0;
   logic [15:0]       run_cycles = '0;
   logic              proc_reset, reg_we, busy, done, pass;
   logic [ADDR_W-1:0] reg_addr, fail_idx;
   logic [DATA_W-1:0] reg_wdata, reg_rdata, exp_data, fail_act, fail_exp;
   logic [ADDR_W:0]   mismatch_count;

   always #5 clk = ~clk;

   proc_test_sequencer #(.DATA_W(DATA_W), .NREG(NREG), .RESET_CYCLES(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .run_cycles     (run_cycles),
      .stop_on_fail   (stop_on_fail),
      .proc_reset     (proc_reset),
      .reg_we         (reg_we),
      .reg_addr       (reg_addr),
      .reg_wdata      (reg_wdata),
      .reg_rdata      (reg_rdata),
      .exp_data       (exp_data),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_idx       (fail_idx),
      .fail_act       (fail_act),
      .fail_exp       (fail_exp),
      .mismatch_count (mismatch_count)
   );

   // Processor register file and expected table; corrupt[] models registers the program altered.
   logic [31:0] regs [NREG];
   logic [31:0] exp_tab [NREG];
   logic [31:0] cval [NREG];
   logic        corrupt [NREG];
   logic        clr = 1'b0;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[reg_addr] <= reg_wdata;
      end
   end

   assign reg_rdata = corrupt[reg_addr] ? cval[reg_addr] : regs[reg_addr];
   assign exp_data  = exp_tab[reg_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   typedef struct {
      int          lat;
      logic        pass;
      logic [4:0]  idx;
      logic [31:0] act;
      logic [31:0] expv;
      logic [5:0]  cnt;
   } exp_t;

   exp_t sbq [$];
   int   start_cyc = 0;

   function automatic exp_t mk(input int lat, input logic p, input logic [4:0] idx,
                               input logic [31:0] act, input logic [31:0] expv, input logic [5:0] cnt);
      exp_t e;
      e.lat = lat; e.pass = p; e.idx = idx; e.act = act; e.expv = expv; e.cnt = cnt;
      return e;
   endfunction

   // Scoreboard monitor: each rising done pops one expected result.
   logic done_d = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (done && !done_d) begin
         if (sbq.size() == 0) begin
            check("unexpected_done", done_d, 1'b1);
         end else begin
            e = sbq.pop_front();
            check("latency", 64'(cyc - start_cyc), 64'(e.lat));
            check("pass", pass, e.pass);
            check("fail_idx", fail_idx, e.idx);
            check("fail_act", fail_act, e.act);
            check("fail_exp", fail_exp, e.expv);
            check("mismatch_count", mismatch_count, e.cnt);
         end
      end
      done_d = done;
   end

   // Trace monitor: cumulative counters, read as deltas by the stimulus.
   int   we_cnt = 0, addr_err = 0, wd_err = 0, low_cnt = 0, next_addr = 1;
   logic we_prev = 1'b0;
   always @(negedge clk) begin
      if (reg_we) begin
         if (!we_prev) next_addr = 1;
         we_cnt++;
         if (int'(reg_addr) != next_addr) addr_err++;
         if (reg_wdata !== 32'hcafebabe) wd_err++;
         next_addr++;
      end
      if (!proc_reset) low_cnt++;
      we_prev = reg_we;
   end

   task automatic check_reset_values(input string tag);
      check({tag, " busy"}, busy, 1'b0);
      check({tag, " done"}, done, 1'b0);
      check({tag, " pass"}, pass, 1'b0);
      check({tag, " proc_reset"}, proc_reset, 1'b1);
      check({tag, " reg_we"}, reg_we, 1'b0);
      check({tag, " reg_addr"}, reg_addr, 5'd0);
      check({tag, " fail_idx"}, fail_idx, 5'd0);
      check({tag, " fail_act"}, fail_act, 32'd0);
      check({tag, " fail_exp"}, fail_exp, 32'd0);
      check({tag, " mismatch_count"}, mismatch_count, 6'd0);
   endtask

   task automatic clean_tables();
      for (int i = 0; i < NREG; i++) begin
         exp_tab[i] = 32'hcafebabe;
         corrupt[i] = 1'b0;
         cval[i]    = '0;
      end
   endtask

   task automatic run_test(input logic [15:0] rc, input logic sof, input exp_t e, input string tag);
      int we0, ae0, wd0, low0, n;
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0; start = 1'b1; run_cycles = rc; stop_on_fail = sof;
      we0 = we_cnt; ae0 = addr_err; wd0 = wd_err; low0 = low_cnt;
      sbq.push_back(e);
      @(posedge clk); #1 start_cyc = cyc;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!done && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, " done_seen"}, done, 1'b1);
      @(negedge clk); #1;
      check({tag, " we_cycles"}, 64'(we_cnt - we0), 64'd31);
      check({tag, " we_addr_errors"}, 64'(addr_err - ae0), 64'd0);
      check({tag, " wdata_errors"}, 64'(wd_err - wd0), 64'd0);
      check({tag, " run_cycles_seen"}, 64'(low_cnt - low0), 64'(rc));
      repeat (3) @(negedge clk);
      #1;
      check({tag, " done_hold"}, done, 1'b1);
      check({tag, " fail_idx_hold"}, fail_idx, e.idx);
   endtask

   initial begin
      int low0, n;
      clean_tables();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("por");
      reset = 1'b0;

      run_test(16'd50, 1'b0, mk(115, 1'b1, 5'd0, 32'd0, 32'd0, 6'd0), "all_match");

      exp_tab[7] = 32'd5; corrupt[7] = 1'b1; cval[7] = 32'd0;
      run_test(16'd10, 1'b1, mk(51, 1'b0, 5'd7, 32'd0, 32'd5, 6'd1), "stop_r7");

      clean_tables();
      corrupt[3] = 1'b1; cval[3] = 32'h11111111; exp_tab[20] = 32'd0;
      run_test(16'd5, 1'b0, mk(70, 1'b0, 5'd3, 32'h11111111, 32'hcafebabe, 6'd2), "scan_r3_r20");

      clean_tables();
      run_test(16'd0, 1'b0, mk(65, 1'b1, 5'd0, 32'd0, 32'd0, 6'd0), "zero_run");

      // Reset during RUN cycle 10, with a start pulse in RUN that must be ignored.
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0; start = 1'b1; run_cycles = 16'd50; stop_on_fail = 1'b0;
      low0 = low_cnt;
      @(negedge clk); start = 1'b0;
      n = 0;
      while ((low_cnt - low0) < 5 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      check("start_ignored busy", busy, 1'b1);
      check("start_ignored proc_reset", proc_reset, 1'b0);
      check("start_ignored reg_we", reg_we, 1'b0);
      while ((low_cnt - low0) < 10 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check("midrun reached_cycle10", 64'(low_cnt - low0), 64'd10);
      reset = 1'b1;
      @(negedge clk); #1;
      check_reset_values("midrun");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("after_reset idle busy", busy, 1'b0);

      run_test(16'd3, 1'b0, mk(68, 1'b1, 5'd0, 32'd0, 32'd0, 6'd0), "recover");

      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_test_sequencer.md
PROC_TEST_SEQUENCER -- requirements
Module: proc_test_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: register and expected-value width.
REQ-002 Parameter NREG, default 32: register count; register 0 is never written or checked; ADDR_W = clog2(NREG).
REQ-003 Parameter RESET_CYCLES, default 2: cycles proc_reset is held after init, minimum 1.
REQ-004 Parameter INIT_PATTERN, default 32'hcafebabe, truncated or zero-extended to DATA_W: fill value for registers 1..NREG-1.
REQ-005 clk  in  1  sole clock, rising edge active.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  begin a test run; sampled in IDLE or DONE only.
REQ-008 run_cycles  in  16  processor run budget, captured at start.
REQ-009 stop_on_fail  in  1  mode, captured at start: 1 = end on first mismatch, 0 = scan all registers.
REQ-010 proc_reset  out  1  reset to processor under test.
REQ-011 reg_we  out  1  write strobe to processor register file.
REQ-012 reg_addr  out  ADDR_W  register-file and expected-table address.
REQ-013 reg_wdata  out  DATA_W  always INIT_PATTERN.
REQ-014 reg_rdata  in  DATA_W  combinational read of reg_addr.
REQ-015 exp_data  in  DATA_W  combinational expected value for reg_addr.
REQ-016 busy / done / pass  out  1 each  run active / results valid / all checked registers matched.
REQ-017 fail_idx  out  ADDR_W; fail_act, fail_exp  out  DATA_W each: first mismatch details.
REQ-018 mismatch_count  out  ADDR_W+1  number of mismatching registers.

Function
REQ-019 States: IDLE, INIT, HOLD, RUN, CHECK, DONE.
REQ-020 IDLE or DONE with start=1 -> INIT next edge; run_cycles and stop_on_fail are captured; pass, fail_*, and mismatch_count are cleared; done drops.
REQ-021 start in INIT, HOLD, RUN, or CHECK is ignored.
REQ-022 INIT: reg_we=1 with reg_addr stepping 1..NREG-1, one per cycle (NREG-1 cycles), then -> HOLD.
REQ-023 HOLD: lasts exactly RESET_CYCLES cycles with reg_we=0, then -> RUN, or -> CHECK when the captured run_cycles=0.
REQ-024 RUN: proc_reset=0 for exactly run_cycles cycles, then -> CHECK.
REQ-025 proc_reset=1 in every state except RUN, so the processor is frozen during init and check.
REQ-026 CHECK: reg_addr steps 1..NREG-1, one per cycle; reg_rdata and exp_data are compared in the same cycle.
REQ-027 Each mismatch increments mismatch_count; the first mismatch also loads fail_idx, fail_act, and fail_exp, which later mismatches do not overwrite.
REQ-028 With stop_on_fail=1, the first mismatch -> DONE on the next edge; otherwise CHECK ends after address NREG-1.
REQ-029 DONE: done=1, busy=0, pass = (mismatch_count==0); all results hold until the next start or reset.
REQ-030 busy=1 in INIT, HOLD, RUN, and CHECK.
REQ-031 Latency with no early stop: done first high (NREG-1)+RESET_CYCLES+run_cycles+(NREG-1)+1 edges after the edge that samples start.
REQ-032 The run counter is 16 bits and does not wrap; run_cycles=16'hFFFF runs 65535 cycles.
REQ-033 mismatch_count saturates at NREG-1.

Reset
REQ-034 reset=1 -> IDLE on the next edge, from any state, including mid-run.
REQ-035 Reset values: busy=0, done=0, pass=0, proc_reset=1, reg_we=0, reg_addr=0, fail_idx=0, fail_act=0, fail_exp=0, mismatch_count=0, counters=0.
REQ-036 reset takes priority over start in the same cycle.

Structure
REQ-037 Shared package proc_test_pkg holds the state enumeration and the INIT_PATTERN default.
REQ-038 One sub-module, tb_cycle_counter, provides a loadable 16-bit down-counter with zero flag, used by HOLD and RUN.
REQ-039 Address stepping for INIT and CHECK shares a single ADDR_W counter.

Verification
REQ-040 NREG=32, RESET_CYCLES=2, run_cycles=50, all registers match -> done at edge 115, pass=1, mismatch_count=0.
REQ-041 Register 7 reads 0 against expected 5, stop_on_fail=1 -> DONE one edge after address 7 checked, fail_idx=7, fail_act=0, fail_exp=5, mismatch_count=1, pass=0.
REQ-042 Registers 3 and 20 mismatch, stop_on_fail=0 -> full scan, fail_idx=3, mismatch_count=2, pass=0.
REQ-043 run_cycles=0 -> proc_reset never deasserts; CHECK follows HOLD directly; done at edge 65.
REQ-044 reset asserted during RUN cycle 10 -> IDLE next edge, all outputs at reset values, proc_reset=1; start pulsed in RUN is ignored.
REQ-045 INIT trace: reg_we high for exactly 31 cycles, reg_addr 1..31, reg_wdata=cafebabe; register 0 is never addressed.
